// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side word unpacker.
// - FIFO_DATA_WIDTH : width of one FIFO entry.
// - DEFAULT_BYTES   : default number of entries packed per output word.
// - flush_state_e   : flush sequencing FSM states.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_BYTES   = 4;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FLUSH_WAIT = 2'd1,
        DONE       = 2'd2
    } flush_state_e;

endpackage

// File: rtl/fifo_word_unpacker_if.sv
// Output word stream of the unpacker.
// - m_data  : packed word, entry 0 in the LSBs
// - m_keep  : per-byte-lane valid mask
// - m_last  : marks the word produced by a flush
// - m_valid : word valid
// - m_ready : downstream accepts when m_valid && m_ready
// master = producer (unpacker), slave = consumer.
interface fifo_word_unpacker_if #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
    parameter int unsigned BYTES      = fifo_pkg::DEFAULT_BYTES
);

    logic [BYTES*DATA_WIDTH-1:0] m_data;
    logic [BYTES-1:0]            m_keep;
    logic                        m_last;
    logic                        m_valid;
    logic                        m_ready;

    modport master (
        output m_data,
        output m_keep,
        output m_last,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_keep,
        input  m_last,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/word_out_reg.sv
// One-entry valid/ready holding register for a packed word.
// - r_clk, rst     : clock and synchronous active-high reset
// - load_i         : capture load_*_i and raise valid; only asserted when free_o is high
// - load_data_i/load_keep_i/load_last_i : word to capture
// - free_o         : register empty or being drained this cycle
// - valid_o/ready_i: output handshake
// - data_o/keep_o/last_o : held word, stable while valid_o && !ready_i
module word_out_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BYTES = 4
) (
    input  logic             r_clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic [BYTES-1:0] load_keep_i,
    input  logic             load_last_i,
    output logic             free_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [BYTES-1:0] keep_o,
    output logic             last_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [BYTES-1:0] keep_q, keep_d;
    logic             last_q, last_d;

    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
            keep_d  = load_keep_i;
            last_d  = load_last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge r_clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/fifo_word_unpacker.sv
// Read-domain FIFO consumer: drains entries while the FIFO is non-empty and packs BYTES
// consecutive entries little-endian into one word on a valid/ready stream with a keep mask.
// A flush pulse emits any partial word (m_last=1) and then pulses flush_done.
// - r_clk, rst       : clock, synchronous active-high reset
// - fifo_empty       : FIFO empty flag
// - fifo_rd_en       : FIFO read strobe; fifo_data valid the following cycle
// - fifo_data        : FIFO read data
// - flush            : request to emit the partial word
// - flush_done       : one-cycle pulse when the flush has completed
// - busy             : anything buffered, in flight, pending or presented
// - words_out        : accepted-word counter, wraps
// - m                : output word stream (master)
module fifo_word_unpacker
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned BYTES      = DEFAULT_BYTES,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  r_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_out,
    fifo_word_unpacker_if.master  m
);

    localparam int unsigned CW = $clog2(BYTES + 1);
    localparam int unsigned WW = BYTES * DATA_WIDTH;
    localparam logic [CW:0]   BytesExt = (CW + 1)'(BYTES);
    localparam logic [CW-1:0] BytesCnt = CW'(BYTES);

    flush_state_e         state_q, state_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 inflight_q, inflight_d;
    logic [WW-1:0]        acc_q, acc_d;
    logic [BYTES-1:0]     keep_q, keep_d;
    logic [CNT_WIDTH-1:0] words_out_q, words_out_d;

    logic             out_free;
    logic             load;
    logic [BYTES-1:0] load_keep;
    logic             load_last;
    logic             accept;

    // Credit: bytes held plus the byte in flight must leave room in the accumulator, so a
    // returning byte can never collide with a full accumulator.
    assign fifo_rd_en = !rst && !fifo_empty && !flush_pend_q &&
                        (({1'b0, cnt_q} + (CW + 1)'(inflight_q)) < BytesExt);
    assign inflight_d = fifo_rd_en;

    assign accept      = m.m_valid && m.m_ready;
    assign words_out_d = words_out_q + CNT_WIDTH'(accept);

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        keep_d       = keep_q;
        load         = 1'b0;
        load_keep    = '1;
        load_last    = 1'b0;
        flush_done   = 1'b0;

        if (inflight_q) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (cnt_q == CW'(i)) begin
                    acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
                    keep_d[i]                         = 1'b1;
                end
            end
            cnt_d = cnt_q + CW'(1);
        end

        if (cnt_q == BytesCnt && out_free) begin
            load      = 1'b1;
            load_keep = '1;
            load_last = 1'b0;
            cnt_d     = '0;
            acc_d     = '0;
            keep_d    = '0;
        end

        case (state_q)
            FILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                    state_d      = FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                // A full accumulator drains through the normal path above; only a
                // partial one is pushed out here with m_last set.
                if (!inflight_q) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else if (cnt_q != BytesCnt && out_free) begin
                        load      = 1'b1;
                        load_keep = keep_q;
                        load_last = 1'b1;
                        cnt_d     = '0;
                        acc_d     = '0;
                        keep_d    = '0;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                flush_done   = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (rst) begin
            state_q      <= FILL;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            acc_q        <= '0;
            keep_q       <= '0;
            words_out_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            inflight_q   <= inflight_d;
            acc_q        <= acc_d;
            keep_q       <= keep_d;
            words_out_q  <= words_out_d;
        end
    end

    word_out_reg #(
        .WIDTH (WW),
        .BYTES (BYTES)
    ) u_word_out_reg (
        .r_clk       (r_clk),
        .rst         (rst),
        .load_i      (load),
        .load_data_i (acc_q),
        .load_keep_i (load_keep),
        .load_last_i (load_last),
        .free_o      (out_free),
        .valid_o     (m.m_valid),
        .ready_i     (m.m_ready),
        .data_o      (m.m_data),
        .keep_o      (m.m_keep),
        .last_o      (m.m_last)
    );

    assign busy      = (cnt_q != '0) || inflight_q || flush_pend_q || m.m_valid;
    assign words_out = words_out_q;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Self-checking bench for fifo_word_unpacker: a queue-based FIFO feeds the DUT and a
// byte-grouping reference model predicts the output word stream.
module tb_fifo_word_unpacker;

    localparam int unsigned NB    = 4;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic             r_clk = 1'b0;
    logic             rst;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic [7:0]       fifo_data  = 8'h00;
    logic             flush;
    logic             flush_done;
    logic             busy;
    logic [CNT_W-1:0] words_out;

    fifo_word_unpacker_if #(.DATA_WIDTH(8), .BYTES(NB)) m_if ();

    fifo_word_unpacker #(
        .DATA_WIDTH (8),
        .BYTES      (NB),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .r_clk      (r_clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .words_out  (words_out),
        .m          (m_if)
    );

    always #5 r_clk = ~r_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] pend[$];
    word_t      exp_q[$];
    int         exp_total = 0;
    int         pops      = 0;
    int         fd_count  = 0;
    logic       force_empty = 1'b0;

    // FIFO model: one-cycle read latency, empty flag registered.
    always begin
        @(posedge r_clk);
        if (fifo_rd_en === 1'b1) begin
            n_cmp++;
            if (fifo_q.size() == 0 || fifo_empty) begin
                n_err++;
                $display("FAIL fifo_read: strobe with empty=%b depth=%0d, required no read",
                         fifo_empty, fifo_q.size());
            end else begin
                fifo_data <= fifo_q.pop_front();
                pops++;
            end
        end
        fifo_empty <= force_empty || (fifo_q.size() == 0);
    end

    // Output monitor: scoreboard on accept, stability while stalled, flush_done pulses.
    logic        hold_v = 1'b0;
    word_t       hold_w;
    always begin
        @(negedge r_clk);
        #1;
        if (rst !== 1'b0) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_cmp++;
                if (m_if.m_valid !== 1'b1 ||
                    {m_if.m_data, m_if.m_keep, m_if.m_last} !== hold_w) begin
                    n_err++;
                    $display("FAIL stall_stable: got v=%b %h/%b/%b, required v=1 %h/%b/%b",
                             m_if.m_valid, m_if.m_data, m_if.m_keep, m_if.m_last,
                             hold_w.data, hold_w.keep, hold_w.last);
                end
            end
            if (m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL word: got unexpected %h/%b/%b, required no word",
                             m_if.m_data, m_if.m_keep, m_if.m_last);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    if ({m_if.m_data, m_if.m_keep, m_if.m_last} !== e) begin
                        n_err++;
                        $display("FAIL word: got %h/%b/%b, required %h/%b/%b",
                                 m_if.m_data, m_if.m_keep, m_if.m_last, e.data, e.keep, e.last);
                    end
                end
            end
            hold_v = (m_if.m_valid === 1'b1) && (m_if.m_ready === 1'b0);
            hold_w = {m_if.m_data, m_if.m_keep, m_if.m_last};
            if (flush_done === 1'b1) fd_count++;
        end
    end

    // Reference model: bytes group into words in arrival order; a flush emits the remainder.
    task automatic emit_word(input logic last);
        word_t w;
        w.data = '0;
        w.keep = '0;
        w.last = last;
        for (int i = 0; i < pend.size(); i++) begin
            w.data[i*8 +: 8] = pend[i];
            w.keep[i]        = 1'b1;
        end
        exp_q.push_back(w);
        exp_total++;
        pend.delete();
    endtask

    task automatic feed(input logic [7:0] b);
        fifo_q.push_back(b);
        pend.push_back(b);
        if (pend.size() == NB) emit_word(1'b0);
    endtask

    task automatic model_flush();
        if (pend.size() != 0) emit_word(1'b1);
    endtask

    task automatic model_reset();
        pend.delete();
        exp_total = 0;
    endtask

    task automatic step(input bit rnd);
        @(negedge r_clk);
        if (rnd) begin
            m_if.m_ready = ($urandom_range(0, 2) != 0);
            force_empty  = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic wait_idle(input int max, input bit rnd);
        bit ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            step(rnd);
            #1;
            if (exp_q.size() == 0 && fifo_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL drain_timeout: exp_left=%0d fifo_left=%0d busy=%b, required 0/0/0",
                     exp_q.size(), fifo_q.size(), busy);
        end
    endtask

    task automatic wait_fifo_drained(input int max, input bit rnd);
        bit ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            step(rnd);
            if (fifo_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL fifo_drain_timeout: left=%0d, required 0", fifo_q.size());
        end
    endtask

    task automatic wait_flush_done(input int target, input int max, input bit rnd);
        for (int c = 0; c < max && fd_count < target; c++) step(rnd);
        repeat (3) step(rnd);
        #1;
        n_cmp++;
        if (fd_count !== target) begin
            n_err++;
            $display("FAIL flush_done_count: got %0d, required %0d", fd_count, target);
        end
    endtask

    task automatic check_words(input string tag);
        n_cmp++;
        if (words_out !== CNT_W'(exp_total)) begin
            n_err++;
            $display("FAIL words_out_%s: got %0d, required %0d", tag, words_out,
                     CNT_W'(exp_total));
        end
    endtask

    task automatic test_reset();
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst          = 1'b1;
        flush        = 1'b0;
        force_empty  = 1'b0;
        m_if.m_ready = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) feed(b[i]);
        @(posedge r_clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge r_clk);
            #1;
            n_cmp++;
            if ({fifo_rd_en, m_if.m_valid, words_out, busy, flush_done} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: rd=%b v=%b words=%0d busy=%b fd=%b, required 0",
                         fifo_rd_en, m_if.m_valid, words_out, busy, flush_done);
            end
            n_cmp++;
            if ({m_if.m_data, m_if.m_keep, m_if.m_last} !== '0) begin
                n_err++;
                $display("FAIL reset_word: got %h/%b/%b, required 0", m_if.m_data,
                         m_if.m_keep, m_if.m_last);
            end
        end
        @(negedge r_clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_pack();
        wait_idle(60, 1'b0);
        check_words("basic");
    endtask

    task automatic test_backpressure();
        step(1'b0);
        m_if.m_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 12; i++) feed(8'(i));
        repeat (40) step(1'b0);
        #1;
        n_cmp++;
        if (pops !== 8 || fifo_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_reads: got %0d reads rd_en=%b, required 8 reads rd_en=0",
                     pops, fifo_rd_en);
        end
        n_cmp++;
        if (m_if.m_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure_hold: v=%b busy=%b, required 1/1", m_if.m_valid, busy);
        end
        m_if.m_ready = 1'b1;
        wait_idle(100, 1'b0);
        check_words("backpressure");
    endtask

    task automatic test_partial_flush();
        int fd0;
        feed(8'hAA);
        feed(8'hBB);
        wait_fifo_drained(20, 1'b0);
        repeat (3) step(1'b0);
        fd0 = fd_count;
        flush = 1'b1;
        model_flush();
        step(1'b0);
        // Second cycle of flush lands in FLUSH_WAIT and must be ignored.
        step(1'b0);
        flush = 1'b0;
        wait_flush_done(fd0 + 1, 20, 1'b0);
        wait_idle(40, 1'b0);
        check_words("partial");
    endtask

    task automatic test_empty_flush();
        int fd0 = fd_count;
        int vcnt = 0;
        step(1'b0);
        flush = 1'b1;
        step(1'b0);
        flush = 1'b0;
        #1;
        if (m_if.m_valid !== 1'b0) vcnt++;
        n_cmp++;
        if (flush_done !== 1'b0) begin
            n_err++;
            $display("FAIL empty_flush_t1: flush_done=%b, required 0", flush_done);
        end
        step(1'b0);
        #1;
        if (m_if.m_valid !== 1'b0) vcnt++;
        n_cmp++;
        if (flush_done !== 1'b1) begin
            n_err++;
            $display("FAIL empty_flush_t2: flush_done=%b, required 1", flush_done);
        end
        step(1'b0);
        #1;
        if (m_if.m_valid !== 1'b0) vcnt++;
        n_cmp++;
        if (flush_done !== 1'b0 || vcnt != 0 || fd_count != fd0 + 1) begin
            n_err++;
            $display("FAIL empty_flush_t3: fd=%b valid_cycles=%0d pulses=%0d, required 0/0/1",
                     flush_done, vcnt, fd_count - fd0);
        end
    endtask

    task automatic test_flush_race();
        int fd0 = fd_count;
        for (int i = 0; i < 4; i++) feed(8'($urandom));
        // The negedge after the 4th pop is the cycle that byte returns.
        wait_fifo_drained(20, 1'b0);
        flush = 1'b1;
        model_flush();
        step(1'b0);
        flush = 1'b0;
        wait_flush_done(fd0 + 1, 20, 1'b0);
        wait_idle(40, 1'b0);
        check_words("race");
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 3; i++) feed(8'($urandom));
        wait_fifo_drained(20, 1'b0);
        // Two bytes held, third in flight.
        rst = 1'b1;
        model_reset();
        step(1'b0);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (words_out !== '0 || m_if.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midword_reset: words=%0d v=%b busy=%b, required 0/0/0",
                     words_out, m_if.m_valid, busy);
        end
        for (int i = 0; i < 4; i++) feed(8'($urandom));
        wait_idle(40, 1'b0);
        check_words("midword");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 64; i++) feed(8'($urandom));
        wait_idle(300, 1'b0);
        check_words("wrap");
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) feed(8'($urandom));
            wait_fifo_drained(400, 1'b1);
            repeat (3) step(1'b1);
            if (pend.size() != 0 || $urandom_range(0, 1) == 1) begin
                int fd0 = fd_count;
                flush = 1'b1;
                model_flush();
                step(1'b1);
                flush = 1'b0;
                wait_flush_done(fd0 + 1, 200, 1'b1);
            end
        end
        step(1'b0);
        m_if.m_ready = 1'b1;
        force_empty  = 1'b0;
        wait_idle(300, 1'b0);
        check_words("random");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        m_if.m_ready = 1'b1;
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_partial_flush();
        test_empty_flush();
        test_flush_race();
        test_reset_mid_word();
        test_wrap();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_words: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
